// File: rtl/ssg_scan_mux_if.sv
// ssg_scan_mux_if: display data in, scanned 7-segment pins out.
// master drives digit codes and controls; slave is the scanner.
interface ssg_scan_mux_if #(
  parameter int N_DIGITS = 4
);
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  logic [4*N_DIGITS-1:0] bcd;
  logic [N_DIGITS-1:0]   dp;
  logic                  load;
  logic                  blank_lz;
  logic                  hex_mode;
  logic [6:0]            ssg;
  logic                  dp_o;
  logic [N_DIGITS-1:0]   an;
  logic [IW-1:0]         digit_idx;
  logic                  frame_done;

  modport master (
    output bcd, dp, load, blank_lz, hex_mode,
    input  ssg, dp_o, an, digit_idx, frame_done
  );

  modport slave (
    input  bcd, dp, load, blank_lz, hex_mode,
    output ssg, dp_o, an, digit_idx, frame_done
  );
endinterface

// File: rtl/ssg_scan_mux.sv
// ssg_scan_mux: time-multiplexed N-digit 7-segment driver with
// double-buffered data, leading-zero blanking and hex/BCD glyphs.
module ssg_scan_mux #(
  parameter int N_DIGITS       = 4,
  parameter int CLK_DIV        = 50000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  ssg_scan_mux_if.slave bus
);
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [PW-1:0] PMAX = PW'(CLK_DIV - 1);
  localparam logic [IW-1:0] IMAX = IW'(N_DIGITS - 1);

  localparam logic [6:0] SEG_INV =
    {7{SEG_ACTIVE_LOW != 0}};
  localparam logic DP_INV = (SEG_ACTIVE_LOW != 0);
  localparam logic [N_DIGITS-1:0] AN_INV =
    {N_DIGITS{AN_ACTIVE_LOW != 0}};

  logic [PW-1:0]         r_presc;
  logic [IW-1:0]         r_idx;
  logic                  r_frame;
  logic [4*N_DIGITS-1:0] r_bcd;
  logic [N_DIGITS-1:0]   r_dp;
  logic [6:0]            r_ssg;
  logic                  r_dpo;
  logic [N_DIGITS-1:0]   r_an;

  logic                  w_tick;
  logic [3:0]            w_code;
  logic                  w_dp_sel;
  logic                  w_zsel;
  logic                  w_blank;
  logic [N_DIGITS-1:0]   w_an;
  logic [N_DIGITS-1:0]   w_zero;
  logic [6:0]            w_glyph;

  assign w_tick = (r_presc == PMAX);

  // Refresh prescaler: one tick per digit slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  // Digit scan counter; frame pulse follows the wrap edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx   <= '0;
      r_frame <= 1'b0;
    end else begin
      r_frame <= w_tick && (r_idx == IMAX);
      if (w_tick) begin
        r_idx <= (r_idx == IMAX) ? '0 : r_idx + 1'b1;
      end
    end
  end

  // Shadow copy of digit codes and dots, taken only on load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bcd <= '0;
      r_dp  <= '0;
    end else if (bus.load) begin
      r_bcd <= bus.bcd;
      r_dp  <= bus.dp;
    end
  end

  // w_zero[i]: digits i..top hold zero and request no dot.
  always_comb begin
    w_zero = '0;
    w_zero[N_DIGITS-1] =
      (r_bcd[4*(N_DIGITS-1) +: 4] == 4'h0) &&
      !r_dp[N_DIGITS-1];
    for (int i = N_DIGITS - 2; i >= 0; i--) begin
      w_zero[i] = w_zero[i+1] &&
                  (r_bcd[4*i +: 4] == 4'h0) && !r_dp[i];
    end
  end

  // Select the current digit's code, dot, zero run and enable.
  always_comb begin
    w_code   = 4'h0;
    w_dp_sel = 1'b0;
    w_zsel   = 1'b0;
    w_an     = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (r_idx == IW'(i)) begin
        w_code   = r_bcd[4*i +: 4];
        w_dp_sel = r_dp[i];
        w_zsel   = w_zero[i];
        w_an[i]  = 1'b1;
      end
    end
  end

  assign w_blank = bus.blank_lz && (r_idx != '0) && w_zsel;

  // Glyph lookup, active-high {g,f,e,d,c,b,a}.
  always_comb begin
    w_glyph = 7'h00;
    unique case (w_code)
      4'h0: w_glyph = 7'h3F;
      4'h1: w_glyph = 7'h06;
      4'h2: w_glyph = 7'h5B;
      4'h3: w_glyph = 7'h4F;
      4'h4: w_glyph = 7'h66;
      4'h5: w_glyph = 7'h6D;
      4'h6: w_glyph = 7'h7D;
      4'h7: w_glyph = 7'h07;
      4'h8: w_glyph = 7'h7F;
      4'h9: w_glyph = 7'h6F;
      4'hA: w_glyph = bus.hex_mode ? 7'h77 : 7'h40;
      4'hB: w_glyph = bus.hex_mode ? 7'h7C : 7'h40;
      4'hC: w_glyph = bus.hex_mode ? 7'h39 : 7'h40;
      4'hD: w_glyph = bus.hex_mode ? 7'h5E : 7'h40;
      4'hE: w_glyph = bus.hex_mode ? 7'h79 : 7'h40;
      4'hF: w_glyph = bus.hex_mode ? 7'h71 : 7'h40;
    endcase
  end

  // Pin registers: segments, dot and enables update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ssg <= SEG_INV;
      r_dpo <= DP_INV;
      r_an  <= AN_INV;
    end else begin
      r_ssg <= (w_blank ? 7'h00 : w_glyph) ^ SEG_INV;
      r_dpo <= (w_dp_sel && !w_blank) ^ DP_INV;
      r_an  <= w_an ^ AN_INV;
    end
  end

  assign bus.ssg        = r_ssg;
  assign bus.dp_o       = r_dpo;
  assign bus.an         = r_an;
  assign bus.digit_idx  = r_idx;
  assign bus.frame_done = r_frame;
endmodule
